sipo_buffer: RTL
================

Name: sipo_buffer

Overview:
Serial-in, parallel-out block assembler for the SHAKE datapath: collects a stream of WIDTH-bit words into one DEPTH*WIDTH-bit block (e.g. one rate block of lanes) and presents it in parallel to the permutation/absorb stage.
It is the write-side counterpart of the parallel-in, serial-out squeeze buffer.
The word order matches that buffer: the first word received lands in the most-significant slice.
It supports early termination (in_last) with zero padding of the unfilled slots, and valid/ready flow control on both sides.

Parameters:
WIDTH, 64, bits per serial word (one Keccak lane)
DEPTH, 17, words per parallel block (SHAKE256 rate = 17 lanes); legal range DEPTH >= 1

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data/in_last valid
in_ready  output  1  buffer can accept a word this cycle
in_data  input  WIDTH  serial word
in_last  input  1  this word is the final word of the message; close block after it
out_valid  output  1  out_data holds a complete (or closed) block
out_ready  input  1  consumer accepts block this cycle
out_data  output  DEPTH*WIDTH  assembled block
out_words  output  $clog2(DEPTH+1)  number of real words in the block (1..DEPTH)
out_last  output  1  block was closed by in_last

Behaviour:
- Reset: one clock domain (clk). rst is asynchronous and active-high; it takes effect immediately, without a clock edge. Reset forces state FILL, word count 0, out_data all zeros, out_valid=0, out_words=0, out_last=0. Asserting rst mid-block discards the partial block.
- States:
  - FILL: count = 0..DEPTH-1.
  - FULL: block held for the consumer.
- Handshake terms:
  - Input handshake: accept = in_valid && in_ready.
  - Output handshake: drain = out_valid && out_ready.
- in_ready:
  - In FILL: 1.
  - In FULL: equals out_ready. This combinational path is intentional and allows zero-bubble streaming.
- out_valid = (state == FULL), registered.
- Word placement: the k-th accepted word of a block (k = 0-based count) is written to out_data[(DEPTH-k)*WIDTH-1 -: WIDTH]. Slots not yet written read zero.
- FILL, on accept:
  - Store the word and increment count.
  - If count was DEPTH-1, or in_last=1: next state FULL, out_words = count+1, out_last = in_last.
- Latency: out_valid rises on the clock edge that accepts the closing word, so it is visible the following cycle.
- FULL:
  - out_data, out_words and out_last stay stable until drain.
  - Extra input is back-pressured via in_ready.
- On drain without accept: clear out_data to zero, count = 0, out_last = 0, out_words = 0, next state FILL.
- On drain with accept in the same edge:
  - The new block starts with the incoming word in slot 0; all other slots are zero; count = 1.
  - If DEPTH == 1 or in_last=1, the state stays FULL with the new block, out_words = 1, and out_last = in_last.
- in_valid=0 cycles (bubbles) in FILL: no state change; partial contents held.
- Empty blocks cannot be produced. There is no flush without data, so in_last always accompanies a word.
- Counter width: $clog2(DEPTH+1). The counter never exceeds DEPTH and never wraps.
- in_data/in_last are ignored when accept=0.

Decomposition:
- shake_pkg (shared) holds:
  - LANE_WIDTH = 64.
  - Rate constants in lanes for SHAKE128 (21) and SHAKE256 (17).
  - A typedef for the lane type.
- Default parameters are taken from shake_pkg.
- No sub-module. The FSM, counter and slot-write decode fit in one module of roughly 150 lines.

Test Plan:
1. Streaming (WIDTH=8, DEPTH=4): rst pulse, then 0x11, 0x22, 0x33, 0x44 on consecutive cycles with out_ready=0 -> next cycle out_valid=1, out_data=0x11223344, out_words=4, out_last=0, in_ready=0.
2. Early close: 0xAA, then 0xBB with in_last=1 -> out_data=0xAABB0000, out_words=2, out_last=1. After drain: out_data=0, out_valid=0, in_ready=1.
3. Back-pressure plus simultaneous drain and accept: hold a full block 0x11223344 with out_ready=0 for 5 cycles (data stable, in_ready=0). Then out_ready=1 with in_valid=1, in_data=0x55 -> the 0x11223344 block is consumed. The next block completes with 0x66, 0x77, 0x88 as 0x55667788 (no stale bytes), with no lost cycle.
4. Async reset: after accepting 0x01, 0x02, assert rst between clock edges -> out_data=0 and out_valid=0 immediately. After release, 0xA1..0xA4 yields 0xA1A2A3A4, out_words=4.
5. Bubbles: scenario 1 with in_valid=0 inserted randomly between words -> identical out_data and out_words. out_valid rises exactly one cycle after the 4th accept.
6. Single-word last: 0x7E with in_last=1 as the first word -> out_data=0x7E000000, out_words=1, out_last=1. Also build with DEPTH=1: every accepted word yields out_valid the next cycle.

Source files
------------

// File: rtl/shake_pkg.sv
// Shared SHAKE datapath constants and types.
// Lane width, rate sizes in lanes and buffer FSM state encoding.
package shake_pkg;

  localparam int LANE_WIDTH    = 64;
  localparam int SHAKE128_RATE = 21;
  localparam int SHAKE256_RATE = 17;

  typedef logic [LANE_WIDTH-1:0] lane_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } sipo_state_t;

endpackage

// File: rtl/sipo_buffer.sv
// Serial-in, parallel-out block assembler for the SHAKE absorb path.
// First word lands in the most-significant slice; in_last closes early.
module sipo_buffer
  import shake_pkg::*;
#(
  parameter int WIDTH = LANE_WIDTH,
  parameter int DEPTH = SHAKE256_RATE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DEPTH*WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0] out_words,
  output logic                       out_last
);

  localparam int CW = $clog2(DEPTH+1);

  sipo_state_t            state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [DEPTH*WIDTH-1:0] data, data_n;
  logic [CW-1:0]          words, words_n;
  logic                   last, last_n;
  logic                   accept;
  logic                   drain;

  // FULL passes out_ready straight through so a drain can refill at once.
  assign in_ready  = (state == FILL) | out_ready;
  assign accept    = in_valid & in_ready;
  assign drain     = (state == FULL) & out_ready;
  assign out_valid = (state == FULL);
  assign out_data  = data;
  assign out_words = words;
  assign out_last  = last;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = data;
    words_n = words;
    last_n  = last;
    unique case (state)
      FILL: begin
        if (accept) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (cnt == CW'(i))
              data_n[(DEPTH-i)*WIDTH-1 -: WIDTH] = in_data;
          end
          cnt_n = cnt + CW'(1);
          if ((cnt == CW'(DEPTH-1)) || in_last) begin
            state_n = FULL;
            words_n = cnt + CW'(1);
            last_n  = in_last;
          end
        end
      end
      FULL: begin
        if (drain) begin
          data_n  = '0;
          cnt_n   = '0;
          words_n = '0;
          last_n  = 1'b0;
          state_n = FILL;
          if (accept) begin
            data_n[DEPTH*WIDTH-1 -: WIDTH] = in_data;
            cnt_n = CW'(1);
            if ((DEPTH == 1) || in_last) begin
              state_n = FULL;
              words_n = CW'(1);
              last_n  = in_last;
            end
          end
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
      data  <= '0;
      words <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      data  <= data_n;
      words <= words_n;
      last  <= last_n;
    end
  end

endmodule
